// File: rtl/graphics_row_writer.sv
// Packs a valid/ready byte stream MSB-first into 240-bit rows and writes each row
// at base+row of the selected 1-bpp overlay graphic in the row memory.
module graphics_row_writer #(
    parameter int ROW_BITS = 240,
    parameter int ADDR_W   = 9
) (
    input  logic                pixel_clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [1:0]          graphic,
    input  logic                abort,
    input  logic [7:0]          byte_in,
    input  logic                byte_valid,
    output logic                byte_ready,
    output logic                wr_en,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [ROW_BITS-1:0] wr_data,
    output logic                busy,
    output logic                done,
    output logic                error
);

    localparam int BYTES_ROW = ROW_BITS / 8;

    typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

    state_t                state, state_next;
    logic [ADDR_W-1:0]     base;
    logic [7:0]            height;
    logic [7:0]            row;
    logic [4:0]            byte_cnt;
    // Holds the first BYTES_ROW-1 bytes; the final byte goes straight into wr_data.
    logic [ROW_BITS-9:0]   shreg;
    logic                  handshake;
    logic                  last_byte;
    logic                  last_row;
    logic                  start_ok;

    function automatic logic [ADDR_W-1:0] tbl_base(input logic [1:0] g);
        case (g)
            2'd0:    tbl_base = ADDR_W'(0);
            2'd1:    tbl_base = ADDR_W'(144);
            2'd2:    tbl_base = ADDR_W'(192);
            default: tbl_base = ADDR_W'(232);
        endcase
    endfunction

    function automatic logic [7:0] tbl_height(input logic [1:0] g);
        case (g)
            2'd0:    tbl_height = 8'd144;
            2'd1:    tbl_height = 8'd44;
            2'd2:    tbl_height = 8'd38;
            default: tbl_height = 8'd91;
        endcase
    endfunction

    assign last_byte = (byte_cnt == 5'(BYTES_ROW - 1));
    assign last_row  = (row == height - 8'd1);
    assign start_ok  = start & ~abort;
    assign busy      = (state != IDLE);

    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // Abort takes priority everywhere outside IDLE and suppresses wr_en/done.
    always_comb begin
        state_next = state;
        byte_ready = 1'b0;
        wr_en      = 1'b0;
        done       = 1'b0;
        handshake  = 1'b0;
        case (state)
            IDLE: begin
                if (start_ok) state_next = LOAD;
            end
            LOAD: begin
                byte_ready = 1'b1;
                handshake  = byte_valid;
                if (abort)                       state_next = IDLE;
                else if (byte_valid && last_byte) state_next = WRITE;
            end
            WRITE: begin
                if (abort) begin
                    state_next = IDLE;
                end else begin
                    wr_en      = 1'b1;
                    state_next = last_row ? DONE : LOAD;
                end
            end
            DONE: begin
                done       = ~abort;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            base     <= '0;
            height   <= '0;
            row      <= '0;
            byte_cnt <= '0;
            shreg    <= '0;
            wr_addr  <= '0;
            wr_data  <= '0;
            error    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        base     <= tbl_base(graphic);
                        height   <= tbl_height(graphic);
                        row      <= '0;
                        byte_cnt <= '0;
                        error    <= 1'b0;
                    end
                end
                LOAD: begin
                    if (abort) begin
                        error <= 1'b1;
                    end else if (handshake) begin
                        shreg    <= {shreg[ROW_BITS-17:0], byte_in};
                        byte_cnt <= byte_cnt + 5'd1;
                        if (last_byte) begin
                            wr_data <= {shreg, byte_in};
                            wr_addr <= base + ADDR_W'(row);
                        end
                    end
                end
                WRITE: begin
                    if (abort) begin
                        error <= 1'b1;
                    end else begin
                        byte_cnt <= '0;
                        if (!last_row) row <= row + 8'd1;
                    end
                end
                DONE: begin
                    if (abort) error <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_graphics_row_writer.sv
// Bench for graphics_row_writer: table of graphic loads with a write scoreboard,
// plus hand sequences for abort, ignored start and asynchronous reset.
`timescale 1ns/1ps
module tb_graphics_row_writer;

    logic         pixel_clk = 1'b0;
    logic         reset_n;
    logic         start;
    logic [1:0]   graphic;
    logic         abort;
    logic [7:0]   byte_in;
    logic         byte_valid;
    logic         byte_ready;
    logic         wr_en;
    logic [8:0]   wr_addr;
    logic [239:0] wr_data;
    logic         busy;
    logic         done;
    logic         error;

    graphics_row_writer dut (
        .pixel_clk  (pixel_clk),
        .reset_n    (reset_n),
        .start      (start),
        .graphic    (graphic),
        .abort      (abort),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 pixel_clk = ~pixel_clk;

    typedef struct {
        logic [8:0]   addr;
        logic [239:0] data;
    } wr_t;

    typedef struct {
        logic [1:0] g;
        int         mode;
        int         max_gap;
        bit         poke;
        int         base;
        int         height;
    } vec_t;

    wr_t  exp_q[$];
    vec_t vecs[4];
    int   vectors    = 0;
    int   miscompares = 0;
    int   writes_seen = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every write strobe must match the oldest expected row.
    always @(negedge pixel_clk) begin
        if (wr_en === 1'b1) begin
            writes_seen++;
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_write: addr %0d, no write expected", wr_addr);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", 256'(wr_addr), 256'(e.addr));
                check("wr_data", 256'(wr_data), 256'(e.data));
            end
        end
    end

    function automatic logic [7:0] gen(input int mode, input int r, input int j);
        case (mode)
            0:       gen = 8'hA5;
            1:       gen = (j == 0) ? 8'(r) : 8'(j);
            default: gen = 8'((r * 7 + j * 13) ^ 8'h5A);
        endcase
    endfunction

    // Called at a negedge; returns at the negedge after the handshake edge.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        byte_in    = b;
        byte_valid = 1'b1;
        while (byte_ready !== 1'b1 && n < 200) begin
            @(negedge pixel_clk);
            n++;
        end
        if (n >= 200) check("byte_ready_timeout", 256'(byte_ready), 256'(1));
        @(negedge pixel_clk);
    endtask

    task automatic push_row(input int base, input int r, input int mode);
        wr_t e;
        e.addr = 9'(base + r);
        for (int j = 0; j < 30; j++) e.data[239 - 8*j -: 8] = gen(mode, r, j);
        exp_q.push_back(e);
    endtask

    task automatic pulse_start(input logic [1:0] g);
        start   = 1'b1;
        graphic = g;
        @(negedge pixel_clk);
        start   = 1'b0;
        graphic = 2'($urandom);
    endtask

    task automatic run_load(input vec_t v);
        pulse_start(v.g);
        check("start_busy", 256'(busy), 256'(1));
        check("start_error_clr", 256'(error), 256'(0));
        for (int r = 0; r < v.height; r++) begin
            push_row(v.base, r, v.mode);
            for (int j = 0; j < 30; j++) begin
                if (v.max_gap > 0) begin
                    int k = $urandom_range(0, v.max_gap);
                    if (k > 0) begin
                        byte_valid = 1'b0;
                        repeat (k) @(negedge pixel_clk);
                    end
                end
                if (v.poke && r == 1 && j == 10) begin
                    start   = 1'b1;
                    graphic = 2'd0;
                end
                send_byte(gen(v.mode, r, j));
                start = 1'b0;
            end
        end
        byte_valid = 1'b0;
        @(negedge pixel_clk);
        check("done_pulse", 256'(done), 256'(1));
        check("done_busy", 256'(busy), 256'(1));
        @(negedge pixel_clk);
        check("done_low", 256'(done), 256'(0));
        check("idle_busy", 256'(busy), 256'(0));
        check("rows_left", 256'(exp_q.size()), 256'(0));
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        vecs[0] = '{g: 2'd2, mode: 0, max_gap: 0, poke: 1'b0, base: 192, height: 38};
        vecs[1] = '{g: 2'd1, mode: 1, max_gap: 0, poke: 1'b0, base: 144, height: 44};
        vecs[2] = '{g: 2'd0, mode: 2, max_gap: 5, poke: 1'b0, base: 0,   height: 144};
        vecs[3] = '{g: 2'd3, mode: 2, max_gap: 0, poke: 1'b1, base: 232, height: 91};

        reset_n = 1'b0; start = 1'b0; graphic = 2'd0; abort = 1'b0;
        byte_in = 8'h00; byte_valid = 1'b0;
        repeat (2) @(negedge pixel_clk);
        check("rst_busy", 256'(busy), 256'(0));
        check("rst_ready", 256'(byte_ready), 256'(0));
        check("rst_wr_en", 256'(wr_en), 256'(0));
        check("rst_wr_addr", 256'(wr_addr), 256'(0));
        check("rst_wr_data", 256'(wr_data), 256'(0));
        check("rst_done_err", 256'({done, error}), 256'(0));
        reset_n = 1'b1;
        @(negedge pixel_clk);

        for (int i = 0; i < 4; i++) begin
            w0 = writes_seen;
            run_load(vecs[i]);
            check("write_count", 256'(writes_seen - w0), 256'(vecs[i].height));
        end

        // Abort 15 bytes into row 3 of graphic 3: rows 0..2 land, addr 235 never written.
        pulse_start(2'd3);
        for (int r = 0; r < 3; r++) begin
            push_row(232, r, 1);
            for (int j = 0; j < 30; j++) send_byte(gen(1, r, j));
        end
        for (int j = 0; j < 15; j++) send_byte(gen(1, 3, j));
        byte_valid = 1'b0;
        abort = 1'b1;
        @(negedge pixel_clk);
        abort = 1'b0;
        check("abort_busy", 256'(busy), 256'(0));
        check("abort_error", 256'(error), 256'(1));
        check("abort_ready", 256'(byte_ready), 256'(0));
        check("abort_rows", 256'(exp_q.size()), 256'(0));
        abort = 1'b1;
        @(negedge pixel_clk);
        abort = 1'b0;
        check("idle_abort_err", 256'(error), 256'(1));
        start = 1'b1; abort = 1'b1;
        @(negedge pixel_clk);
        start = 1'b0; abort = 1'b0;
        check("start_abort_busy", 256'(busy), 256'(0));
        check("start_abort_err", 256'(error), 256'(1));

        // Abort coinciding with the final byte handshake: no write.
        w0 = writes_seen;
        pulse_start(2'd1);
        check("restart_err_clr", 256'(error), 256'(0));
        for (int j = 0; j < 29; j++) send_byte(gen(0, 0, j));
        byte_in = 8'hA5; byte_valid = 1'b1; abort = 1'b1;
        @(negedge pixel_clk);
        byte_valid = 1'b0; abort = 1'b0;
        check("last_abort_busy", 256'(busy), 256'(0));
        check("last_abort_err", 256'(error), 256'(1));
        repeat (3) @(negedge pixel_clk);
        check("last_abort_nowr", 256'(writes_seen - w0), 256'(0));

        // Asynchronous reset mid-row, then a full load.
        pulse_start(2'd2);
        push_row(192, 0, 0);
        for (int j = 0; j < 30; j++) send_byte(gen(0, 0, j));
        for (int j = 0; j < 10; j++) send_byte(gen(0, 1, j));
        #2 reset_n = 1'b0;
        #1;
        check("arst_outs", 256'({busy, byte_ready, wr_en, done, error}), 256'(0));
        check("arst_addr", 256'(wr_addr), 256'(0));
        check("arst_data", 256'(wr_data), 256'(0));
        byte_valid = 1'b0;
        @(negedge pixel_clk);
        reset_n = 1'b1;
        @(negedge pixel_clk);
        check("arst_idle", 256'(busy), 256'(0));
        w0 = writes_seen;
        run_load(vecs[1]);
        check("post_rst_writes", 256'(writes_seen - w0), 256'(44));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
